// File: rtl/switch_alloc.sv
// switch_alloc: per-output wormhole allocator for the torus router crossbar.
// Each output port arbitrates round-robin among requesting inputs, holds the
// port for the whole packet, and presents registered crossbar selects that
// line up with the registered flit path.
module switch_alloc #(
   parameter int N_PORT = 8,
   parameter int SEL_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_PORT-1:0]       req_valid,
   input  logic [N_PORT*SEL_W-1:0] req_dir,
   input  logic [N_PORT-1:0]       req_tail,
   input  logic [N_PORT-1:0]       out_ready,
   output logic [N_PORT-1:0]       grant,
   output logic [N_PORT-1:0]       xbar_valid,
   output logic [N_PORT*SEL_W-1:0] xbar_sel,
   output logic [N_PORT-1:0]       lock_busy
);

   logic [N_PORT-1:0][SEL_W-1:0]  dir;
   logic [N_PORT-1:0][N_PORT-1:0] req_m;      // [output][input]
   logic [N_PORT-1:0]             lock_q, lock_d;
   logic [N_PORT-1:0][SEL_W-1:0]  owner_q, owner_d;
   logic [N_PORT-1:0][SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [N_PORT-1:0]             xv_q, xv_d;
   logic [N_PORT-1:0][SEL_W-1:0]  sel_q, sel_d;
   logic [N_PORT-1:0]             win_vld;
   logic [N_PORT-1:0][SEL_W-1:0]  win;
   logic [SEL_W-1:0]              idx;

   assign dir = req_dir;

   // Request matrix; output 0 (inject) is never a legal destination
   always_comb begin
      req_m = '0;
      for (int unsigned o = 1; o < N_PORT; o++) begin
         for (int unsigned i = 0; i < N_PORT; i++) begin
            req_m[o][i] = req_valid[i] && (dir[i] == SEL_W'(o));
         end
      end
   end

   // Per-output winner: owner only while locked, else round-robin from rr_ptr
   always_comb begin
      win_vld = '0;
      win     = '0;
      idx     = '0;
      for (int unsigned o = 0; o < N_PORT; o++) begin
         if (!rst && out_ready[o]) begin
            if (lock_q[o]) begin
               win_vld[o] = req_m[o][owner_q[o]];
               win[o]     = owner_q[o];
            end else begin
               for (int unsigned k = 0; k < N_PORT; k++) begin
                  idx = SEL_W'((32'(rr_ptr_q[o]) + k) % N_PORT);
                  if (!win_vld[o] && req_m[o][idx]) begin
                     win_vld[o] = 1'b1;
                     win[o]     = idx;
                  end
               end
            end
         end
      end
   end

   // Fold per-output winners back onto the requesting inputs
   always_comb begin
      grant = '0;
      for (int unsigned o = 0; o < N_PORT; o++) begin
         if (win_vld[o]) grant[win[o]] = 1'b1;
      end
   end

   // Next state: lock on body flits, release and advance pointer on tail
   always_comb begin
      lock_d   = lock_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      xv_d     = '0;
      sel_d    = sel_q;
      for (int unsigned o = 0; o < N_PORT; o++) begin
         if (win_vld[o]) begin
            xv_d[o]  = 1'b1;
            sel_d[o] = win[o];
            if (req_tail[win[o]]) begin
               lock_d[o]   = 1'b0;
               rr_ptr_d[o] = SEL_W'((32'(win[o]) + 32'd1) % N_PORT);
            end else begin
               lock_d[o]  = 1'b1;
               owner_d[o] = win[o];
            end
         end
      end
   end

   // State and crossbar select registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q   <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         xv_q     <= '0;
         sel_q    <= '0;
      end else begin
         lock_q   <= lock_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         xv_q     <= xv_d;
         sel_q    <= sel_d;
      end
   end

   assign xbar_valid = xv_q;
   assign xbar_sel   = sel_q;
   assign lock_busy  = lock_q;

endmodule

// File: tb/tb_switch_alloc.sv
// tb_switch_alloc: randomized wormhole traffic against a per-output reference
// model; expected grants, locks and crossbar selects go through queues that a
// separate monitor drains and compares.
module tb_switch_alloc;
   localparam int N = 8;
   localparam int W = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid, req_tail, out_ready;
   logic [N*W-1:0] req_dir;
   logic [N-1:0]   grant, xbar_valid, lock_busy;
   logic [N*W-1:0] xbar_sel;

   switch_alloc #(.N_PORT(N), .SEL_W(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir),
      .req_tail(req_tail), .out_ready(out_ready), .grant(grant),
      .xbar_valid(xbar_valid), .xbar_sel(xbar_sel), .lock_busy(lock_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // scoreboard queues
   logic [N-1:0] grant_q [$];
   logic [N-1:0] lockx_q [$];
   int           exp_src [N][$];

   // reference model state
   bit m_lock [N];
   int m_own  [N];
   int m_rr   [N];

   // traffic generator state
   int         rem [N];
   int         bub [N];
   int         ill [N];
   logic [2:0] d   [N];
   bit         force_next = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_lock[i] = 0; m_own[i] = 0; m_rr[i] = 0;
         rem[i] = 0; bub[i] = 0; ill[i] = 0; d[i] = 3'd0;
      end
   endtask

   task automatic step();
      logic [N-1:0] v, t, rdy, eg, lk;
      for (int i = 0; i < N; i++) begin
         if (rem[i] == 0 && !force_next && $urandom_range(0, 3) == 0) begin
            bub[i] = 0;
            if ($urandom_range(0, 15) == 0) begin
               d[i] = 3'd0; rem[i] = 1; ill[i] = $urandom_range(1, 4);
            end else begin
               d[i] = 3'($urandom_range(1, 7)); rem[i] = $urandom_range(1, 4);
            end
         end
      end
      rdy = '1;
      for (int o = 0; o < N; o++) rdy[o] = ($urandom_range(0, 4) != 0);
      if (force_next) begin
         rem[1] = 1; d[1] = 3'd2; bub[1] = 0; ill[1] = 0; rdy = '1;
         force_next = 0;
      end
      for (int i = 0; i < N; i++) begin
         v[i] = (rem[i] != 0) && (bub[i] == 0);
         t[i] = (rem[i] == 1);
         req_dir[i*W +: W] = d[i];
      end
      req_valid = v; req_tail = t; out_ready = rdy;

      // reference arbitration: owner if locked, else nearest requester at or after rr
      eg = '0;
      for (int o = 1; o < N; o++) begin
         int w; int best;
         w = -1; best = N;
         if (rdy[o]) begin
            if (m_lock[o]) begin
               if (v[m_own[o]] && d[m_own[o]] == 3'(o)) w = m_own[o];
            end else begin
               for (int i = 0; i < N; i++) begin
                  if (v[i] && d[i] == 3'(o) && ((i - m_rr[o] + N) % N) < best) begin
                     best = (i - m_rr[o] + N) % N; w = i;
                  end
               end
            end
         end
         if (w >= 0) begin
            eg[w] = 1'b1;
            exp_src[o].push_back(w);
            if (t[w]) begin m_lock[o] = 0; m_rr[o] = (w + 1) % N; end
            else begin m_lock[o] = 1; m_own[o] = w; end
         end
      end
      for (int o = 0; o < N; o++) lk[o] = m_lock[o];
      grant_q.push_back(eg);
      lockx_q.push_back(lk);

      // advance each requester for the next cycle
      for (int i = 0; i < N; i++) begin
         if (v[i] && eg[i]) begin
            rem[i]--;
            if (rem[i] > 0 && $urandom_range(0, 3) == 0) bub[i] = $urandom_range(1, 2);
         end else if (rem[i] > 0 && !v[i] && bub[i] > 0) begin
            bub[i]--;
         end else if (v[i] && d[i] == 3'd0) begin
            ill[i]--;
            if (ill[i] == 0) rem[i] = 0;
         end
      end
   endtask

   task automatic reset_mid();
      #1 rst = 1'b1;
      #1;
      chk("rst_lock_busy", int'(lock_busy), 0);
      chk("rst_xbar_valid", int'(xbar_valid), 0);
      chk("rst_grant", int'(grant), 0);
      model_reset();
      req_valid = '0; req_tail = '0; out_ready = '1;
      grant_q.push_back('0);
      lockx_q.push_back('0);
      @(negedge clk);
      #2 rst = 1'b0;
      force_next = 1;
   endtask

   // monitor: grant before the edge, registered outputs just after it
   initial begin
      forever begin
         @(negedge clk);
         if (grant_q.size() > 0) chk("grant", int'(grant), int'(grant_q.pop_front()));
         @(posedge clk);
         #1;
         if (lockx_q.size() > 0) chk("lock_busy", int'(lock_busy), int'(lockx_q.pop_front()));
         for (int o = 0; o < N; o++) begin
            if (xbar_valid[o]) begin
               if (exp_src[o].size() == 0) chk($sformatf("xbar_extra%0d", o), 1, 0);
               else chk($sformatf("xbar_sel%0d", o), int'(xbar_sel[o*W +: W]), exp_src[o].pop_front());
            end else if (exp_src[o].size() > 0) begin
               chk($sformatf("xbar_missing%0d", o), 0, exp_src[o].pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; req_tail = '0; req_dir = '0; out_ready = '1;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("reset_grant", int'(grant), 0);
      chk("reset_xbar_valid", int'(xbar_valid), 0);
      chk("reset_xbar_sel", int'(xbar_sel), 0);
      chk("reset_lock_busy", int'(lock_busy), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #2;
         if (cyc == 1000 || cyc == 2000) reset_mid();
         else step();
      end
      @(posedge clk);
      #2 req_valid = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("grant_q_drained", grant_q.size(), 0);
      chk("lock_q_drained", lockx_q.size(), 0);
      for (int o = 0; o < N; o++) chk($sformatf("xbar_q_drained%0d", o), exp_src[o].size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
